// File: rtl/bsg_mem_var_pkg.sv
// Shared types and helpers for the variable-granularity masked 1r1w RAM.
package bsg_mem_var_pkg;

  typedef enum logic {eINIT, eREADY} init_state_e;

  // Upper bound on data width handled by expand_mask; callers slice the result.
  localparam int unsigned max_width_lp = 1024;

  function automatic logic [max_width_lp-1:0] expand_mask(
    input logic [max_width_lp-1:0] mask,
    input int unsigned             gran
  );
    logic [max_width_lp-1:0] bits;
    bits = '0;
    for (int unsigned i = 0; i < max_width_lp; i++) begin
      bits[i] = (gran == 0) ? 1'b0 : mask[i / gran];
    end
    return bits;
  endfunction

  function automatic int unsigned safe_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bsg_mem_1r1w_sync_mask_write_var_array.sv
// Plain bit-enable storage with a registered read port; no reset, no forwarding.
module bsg_mem_1r1w_sync_mask_write_var_array
  import bsg_mem_var_pkg::*;
#(
  parameter int unsigned width_p       = 32,
  parameter int unsigned els_p         = 16,
  parameter int unsigned addr_width_lp = 4
) (
  input  logic                     clk_i,
  input  logic                     w_v_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic [width_p-1:0]       w_bit_mask_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  logic [width_p-1:0] mem_q [els_p];
  logic [width_p-1:0] r_data_q;

  always_ff @(posedge clk_i) begin
    if (w_v_i) begin
      mem_q[w_addr_i] <= (w_data_i & w_bit_mask_i) | (mem_q[w_addr_i] & ~w_bit_mask_i);
    end
    if (r_v_i) begin
      r_data_q <= mem_q[r_addr_i];
    end
  end

  assign r_data_o = r_data_q;

endmodule

// File: rtl/bsg_mem_1r1w_sync_mask_write_var.sv
// 1r1w synchronous RAM with mask_gran_p-bit write mask and post-reset zeroing.
// Define BSG_MEM_1R1W_MASK_FWD_EN for write-first collisions (default read-first).
module bsg_mem_1r1w_sync_mask_write_var
  import bsg_mem_var_pkg::*;
#(
  parameter int unsigned width_p                     = 32,
  parameter int unsigned els_p                       = 16,
  parameter int unsigned mask_gran_p                 = 8,
  parameter int unsigned latch_last_read_p           = 0,
  parameter int unsigned disable_collision_warning_p = 0,
  localparam int unsigned mask_width_lp = width_p / mask_gran_p,
  localparam int unsigned addr_width_lp = safe_clog2(els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  output logic                     ready_o,
  input  logic                     w_v_i,
  input  logic [mask_width_lp-1:0] w_mask_i,
  input  logic [addr_width_lp-1:0] w_addr_i,
  input  logic [width_p-1:0]       w_data_i,
  input  logic                     r_v_i,
  input  logic [addr_width_lp-1:0] r_addr_i,
  output logic [width_p-1:0]       r_data_o
);

  localparam logic [addr_width_lp:0]   els_lp       = (addr_width_lp+1)'(els_p);
  localparam logic [addr_width_lp-1:0] last_addr_lp = addr_width_lp'(els_p - 1);

  init_state_e              state_q;
  logic                     ready_q;
  logic [addr_width_lp-1:0] init_cnt_q;

  logic w_in_range, r_in_range, user_w_v, user_r_v, collide;
  logic [max_width_lp-1:0] mask_ext, mask_wide;
  logic [width_p-1:0]      user_bit_mask;

  logic                     arr_w_v;
  logic [addr_width_lp-1:0] arr_w_addr;
  logic [width_p-1:0]       arr_w_data, arr_w_mask, arr_r_data, rd_merged;

  logic               rd_v_q, rd_oor_q;
  logic [width_p-1:0] last_q;

  assign w_in_range = ({1'b0, w_addr_i} < els_lp);
  assign r_in_range = ({1'b0, r_addr_i} < els_lp);
  assign user_w_v   = ready_q & w_v_i & w_in_range;
  assign user_r_v   = ready_q & r_v_i & r_in_range;
  assign collide    = user_w_v & user_r_v & (w_addr_i == r_addr_i);

  always_comb begin
    mask_ext                    = '0;
    mask_ext[mask_width_lp-1:0] = w_mask_i;
    mask_wide                   = expand_mask(mask_ext, mask_gran_p);
    user_bit_mask               = mask_wide[width_p-1:0];
  end

  // Init sequencer owns the write port until every entry has been cleared.
  always_comb begin
    if (state_q == eREADY) begin
      arr_w_v    = user_w_v;
      arr_w_addr = w_addr_i;
      arr_w_data = w_data_i;
      arr_w_mask = user_bit_mask;
    end else begin
      arr_w_v    = 1'b1;
      arr_w_addr = init_cnt_q;
      arr_w_data = '0;
      arr_w_mask = '1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= eINIT;
      init_cnt_q <= '0;
      ready_q    <= 1'b0;
    end else begin
      unique case (state_q)
        eINIT: begin
          if (init_cnt_q == last_addr_lp) begin
            init_cnt_q <= '0;
            state_q    <= eREADY;
            ready_q    <= 1'b1;
          end else begin
            init_cnt_q <= init_cnt_q + 1'b1;
          end
        end
        eREADY: state_q <= eREADY;
        default: state_q <= eINIT;
      endcase
    end
  end

  bsg_mem_1r1w_sync_mask_write_var_array #(
    .width_p      (width_p),
    .els_p        (els_p),
    .addr_width_lp(addr_width_lp)
  ) array (
    .clk_i       (clk_i),
    .w_v_i       (arr_w_v),
    .w_addr_i    (arr_w_addr),
    .w_data_i    (arr_w_data),
    .w_bit_mask_i(arr_w_mask),
    .r_v_i       (user_r_v),
    .r_addr_i    (r_addr_i),
    .r_data_o    (arr_r_data)
  );

`ifdef BSG_MEM_1R1W_MASK_FWD_EN
  logic [width_p-1:0] fwd_mask_q, fwd_data_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      fwd_mask_q <= '0;
      fwd_data_q <= '0;
    end else begin
      fwd_mask_q <= collide ? user_bit_mask : '0;
      fwd_data_q <= w_data_i;
    end
  end

  // Array read is naturally read-first; overlay the colliding write's slices.
  assign rd_merged = (arr_r_data & ~fwd_mask_q) | (fwd_data_q & fwd_mask_q);
`else
  assign rd_merged = arr_r_data;
`endif

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_v_q   <= 1'b0;
      rd_oor_q <= 1'b0;
      last_q   <= '0;
    end else begin
      rd_v_q   <= user_r_v;
      rd_oor_q <= ready_q & r_v_i & ~r_in_range;
      if (rd_v_q) begin
        last_q <= rd_merged;
      end else if (rd_oor_q) begin
        last_q <= '0;
      end
    end
  end

  always_comb begin
    if (rd_v_q) begin
      r_data_o = rd_merged;
    end else if ((latch_last_read_p != 0) && !rd_oor_q) begin
      r_data_o = last_q;
    end else begin
      r_data_o = '0;
    end
  end

  assign ready_o = ready_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      if (!ready_q && (w_v_i || r_v_i))
        $error("%m: access while not ready (w_v=%0b r_v=%0b)", w_v_i, r_v_i);
      if (ready_q && w_v_i && !w_in_range)
        $error("%m: write address %0d out of range", w_addr_i);
      if (ready_q && r_v_i && !r_in_range)
        $error("%m: read address %0d out of range", r_addr_i);
`ifndef BSG_MEM_1R1W_MASK_FWD_EN
      if (collide && (disable_collision_warning_p == 0))
        $warning("%m: read/write collision at address %0d", w_addr_i);
`endif
    end
  end
`endif

endmodule

// File: tb/tb_bsg_mem_1r1w_sync_mask_write_var.sv
// Directed bench: byte-granular non-latching instance alongside a 16-bit-granular latching one.
module tb_bsg_mem_1r1w_sync_mask_write_var;

  logic        clk = 1'b0;
  logic        rst;
  logic        w_v, r_v;
  logic [3:0]  w_addr, r_addr;
  logic [31:0] w_data;
  logic [3:0]  wm_a;
  logic [1:0]  wm_b;
  logic        rdy_a, rdy_b;
  logic [31:0] rd_a, rd_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  bsg_mem_1r1w_sync_mask_write_var #(
    .width_p(32), .els_p(16), .mask_gran_p(8),
    .latch_last_read_p(0), .disable_collision_warning_p(1)
  ) dut_a (
    .clk_i(clk), .reset_i(rst), .ready_o(rdy_a),
    .w_v_i(w_v), .w_mask_i(wm_a), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_a)
  );

  bsg_mem_1r1w_sync_mask_write_var #(
    .width_p(32), .els_p(16), .mask_gran_p(16),
    .latch_last_read_p(1), .disable_collision_warning_p(1)
  ) dut_b (
    .clk_i(clk), .reset_i(rst), .ready_o(rdy_b),
    .w_v_i(w_v), .w_mask_i(wm_b), .w_addr_i(w_addr), .w_data_i(w_data),
    .r_v_i(r_v), .r_addr_i(r_addr), .r_data_o(rd_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic init_wait();
    for (int i = 1; i <= 16; i++) begin
      step();
      check("init_ready_a", {31'b0, rdy_a}, (i == 16) ? 32'd1 : 32'd0);
    end
    check("init_ready_b", {31'b0, rdy_b}, 32'd1);
  endtask

  task automatic read_all_zero(input string tag);
    for (int a = 0; a < 16; a++) begin
      r_v    = 1'b1;
      r_addr = 4'(a);
      step();
      check({tag, "_a"}, rd_a, 32'h0);
      check({tag, "_b"}, rd_b, 32'h0);
    end
    r_v = 1'b0;
  endtask

  logic [31:0] coll_exp;

  initial begin
`ifdef BSG_MEM_1R1W_MASK_FWD_EN
    coll_exp = 32'h0000FFFF;
`else
    coll_exp = 32'h00000000;
`endif
    rst = 1'b1; w_v = 1'b0; r_v = 1'b0;
    w_addr = '0; r_addr = '0; w_data = '0; wm_a = '0; wm_b = '0;
    repeat (2) step();
    check("rst_ready_a", {31'b0, rdy_a}, 32'd0);
    check("rst_ready_b", {31'b0, rdy_b}, 32'd0);
    check("rst_rdata_a", rd_a, 32'h0);
    check("rst_rdata_b", rd_b, 32'h0);

    rst = 1'b0;
    init_wait();
    read_all_zero("clear");

    // Full write then partial overwrite of addr 3.
    w_v = 1'b1; w_addr = 4'd3; w_data = 32'hDEADBEEF; wm_a = 4'b1111; wm_b = 2'b11;
    step();
    w_data = 32'h11223344; wm_a = 4'b0101; wm_b = 2'b10;
    step();
    w_v = 1'b0; r_v = 1'b1; r_addr = 4'd3;
    step();
    check("mask_byte_a", rd_a, 32'hDE22BE44);
    check("mask_half_b", rd_b, 32'h1122BEEF);
    r_v = 1'b0;

    // Upper half on a zeroed entry; zero mask is a no-op on A.
    w_v = 1'b1; w_addr = 4'd7; w_data = 32'hAAAA5555; wm_a = 4'b0000; wm_b = 2'b10;
    step();
    w_v = 1'b0; r_v = 1'b1; r_addr = 4'd7;
    step();
    check("zero_mask_a", rd_a, 32'h0);
    check("gran16_b", rd_b, 32'hAAAA0000);

    // Same-cycle read and write of addr 5.
    w_v = 1'b1; w_addr = 4'd5; w_data = 32'hFFFFFFFF; wm_a = 4'b0011; wm_b = 2'b01;
    r_v = 1'b1; r_addr = 4'd5;
    step();
    check("collide_a", rd_a, coll_exp);
    check("collide_b", rd_b, coll_exp);
    w_v = 1'b0;
    step();
    check("post_collide_a", rd_a, 32'h0000FFFF);
    check("post_collide_b", rd_b, 32'h0000FFFF);
    r_v = 1'b0;

    // Read followed by idle cycles: A clears, B holds.
    w_v = 1'b1; w_addr = 4'd9; w_data = 32'h12345678; wm_a = 4'b1111; wm_b = 2'b11;
    step();
    w_v = 1'b0; r_v = 1'b1; r_addr = 4'd9;
    step();
    check("read9_a", rd_a, 32'h12345678);
    check("read9_b", rd_b, 32'h12345678);
    r_v = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("idle_a", rd_a, 32'h0);
      check("idle_latch_b", rd_b, 32'h12345678);
    end

    // Asynchronous reset after writes, then again mid-init at init_cnt=7.
    rst = 1'b1;
    #1;
    check("areset_ready_b", {31'b0, rdy_b}, 32'd0);
    check("areset_rdata_b", rd_b, 32'h0);
    #3;
    rst = 1'b0;
    repeat (7) step();
    check("midinit_ready_a", {31'b0, rdy_a}, 32'd0);
    rst = 1'b1;
    #1;
    check("midinit_rst_ready_a", {31'b0, rdy_a}, 32'd0);
    check("midinit_rst_rdata_b", rd_b, 32'h0);
    #2;
    rst = 1'b0;
    init_wait();
    read_all_zero("reclear");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
